alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
// - Initiator side of the ALU interface: accepts one decoded-register instruction, drives ALU_in1/ALU_in2/ALU_control.
// - Captures result/Zero from the ALU and produces writeback and branch-resolution outputs.
// - Sits between the register-file read stage and the ALU of the multicycle MIPS core.
// - Four-state sequencer; one instruction in flight; throughput 1 instruction / 4 cycles.
// PARAMETERS
// - W  32  datapath width (ALU operand/result width; instr fixed 32 bits)
// PORTS
// - clk           in   1  single clock, rising edge
// - rst           in   1  asynchronous, active-high reset
// - instr_valid   in   1  instruction/operands valid
// - instr_ready   out  1  high only in IDLE; transfer on instr_valid & instr_ready at rising clk
// - instr         in   32 MIPS instruction word
// - pc_in         in   W  PC of the instruction
// - rs_data       in   W  register rs value
// - rt_data       in   W  register rt value
// - ALU_in1       out  W  ALU operand 1 (registered)
// - ALU_in2       out  W  ALU operand 2 (registered)
// - ALU_control   out  4  ALU op code (registered)
// - alu_result    in   W  ALU result (combinational from ALU)
// - alu_zero      in   1  ALU Zero flag
// - wb_valid      out  1  one-cycle pulse: result written back
// - wb_reg        out  5  destination register
// - wb_data       out  W  writeback value
// - br_valid      out  1  one-cycle pulse: branch resolved
// - br_taken      out  1  branch outcome (valid with br_valid)
// - br_target     out  W  pc_in + 4 + (sign_ext(imm) << 2)
// - illegal_op    out  1  one-cycle pulse: unsupported opcode/funct
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; every output 0 except instr_ready=1.
// - IDLE: instr_ready=1; on handshake latch instr, pc_in, rs_data, rt_data -> DECODE.
// - DECODE (1 cycle): register ALU_control, ALU_in1=rs_data, ALU_in2 per table; compute br_target -> EXEC.
// - EXEC (1 cycle): ALU outputs settle; at end of cycle capture alu_result, alu_zero -> DONE.
// - DONE (1 cycle): pulse exactly one of wb_valid / br_valid / illegal_op (or none) -> IDLE.
// - Latency: handshake edge T0 -> pulses high in cycle after edge T2; instr_ready high again after T3.
// - R-type (op 0x00) decode by funct:
//   - 0x20/0x21 -> 0010
//   - 0x22/0x23 -> 0110
//   - 0x24 -> 0000
//   - 0x25 -> 0001
//   - 0x27 -> 1100
//   - 0x2A -> 0111
//   - ALU_in2=rt_data; wb_reg=rd.
// - I-type decode by op:
//   - 0x08/0x09 -> 0010, sign-ext imm
//   - 0x0A -> 0111, sign-ext imm
//   - 0x0C -> 0000, zero-ext imm
//   - 0x0D -> 0001, zero-ext imm
//   - wb_reg=rt.
// - Branches: beq 0x04 / bne 0x05 -> 0110, ALU_in2=rt_data.
//   - br_taken = alu_zero (beq) or ~alu_zero (bne); no wb_valid.
// - Any other op/funct: ALU_control=0010 with operands as R-type; DONE pulses illegal_op only.
// - wb_reg==0: wb_valid suppressed (stays 0); wb_data still updated.
// - Arithmetic: br_target and operand extension are modulo 2^W; no overflow traps (add/sub wrap).
// - ALU_in1/in2/ALU_control and wb_*/br_target hold last value outside their update states.
// - instr_valid outside IDLE is ignored; the instruction must be held by the source until accepted.
// - Reset asserted mid-DECODE/EXEC/DONE: instruction dropped; no pulse is emitted.
// TESTING
// - add $3,$1,$2 (rs=5, rt=7) -> ALU_control=0010; wb_valid, wb_reg=3, wb_data=12 in cycle after T2.
// - addi $4,$1,-1 (rs=0) -> ALU_in2=0xFFFFFFFF; wb_data=0xFFFFFFFF.
// - ori $4,$1,0x8000 (rs=1) -> ALU_in2=0x00008000 (zero-extended); wb_data=0x00008001.
// - beq rs=rt=9, imm=0x0003, pc=0x100 -> br_valid=1, br_taken=1, br_target=0x110, wb_valid=0.
// - bne with rs=rt -> br_taken=0.
// - sub $0,$1,$2 -> wb_valid stays 0.
// - op=0x3F -> illegal_op pulse only.
// - Back-to-back valid: second instruction accepted exactly 4 cycles after the first.
// - Reset pulse during EXEC -> all outputs 0, instr_ready=1, no wb_valid.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Four-state issue sequencer between register read and the ALU: latch, decode, execute, retire.
// One instruction in flight; results/pulses appear in the cycle after the second post-accept edge.
module alu_issue_ctrl #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [31:0]  instr,
  input  logic [W-1:0] pc_in,
  input  logic [W-1:0] rs_data,
  input  logic [W-1:0] rt_data,
  output logic [W-1:0] ALU_in1,
  output logic [W-1:0] ALU_in2,
  output logic [3:0]   ALU_control,
  input  logic [W-1:0] alu_result,
  input  logic         alu_zero,
  output logic         wb_valid,
  output logic [4:0]   wb_reg,
  output logic [W-1:0] wb_data,
  output logic         br_valid,
  output logic         br_taken,
  output logic [W-1:0] br_target,
  output logic         illegal_op
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, DONE} state_t;

  localparam logic [1:0] K_WB  = 2'd0;
  localparam logic [1:0] K_BR  = 2'd1;
  localparam logic [1:0] K_ILL = 2'd2;

  state_t state, state_nxt;

  logic [5:0]   op_q;
  logic [4:0]   rt_f_q;
  logic [15:0]  imm_q;
  logic [W-1:0] pc_q;
  logic [W-1:0] rs_q;
  logic [W-1:0] rt_q;
  logic [1:0]   kind_q;
  logic [4:0]   dest_q;
  logic         bne_q;

  logic [3:0]   dec_ctrl;
  logic [W-1:0] dec_in2;
  logic [1:0]   dec_kind;
  logic [4:0]   dec_dest;
  logic         dec_bne;
  logic [W-1:0] imm_sx;
  logic [W-1:0] imm_zx;

  // rs field is not needed: the register value arrives already read on rs_data
  logic unused_rs_field;
  assign unused_rs_field = ^instr[25:21];

  logic accept;
  assign accept = instr_valid && (state == IDLE);

  assign imm_sx = {{(W-16){imm_q[15]}}, imm_q};
  assign imm_zx = {{(W-16){1'b0}}, imm_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DECODE;
      DECODE:  state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE);
    wb_valid    = (state == DONE) && (kind_q == K_WB) && (wb_reg != 5'd0);
    br_valid    = (state == DONE) && (kind_q == K_BR);
    illegal_op  = (state == DONE) && (kind_q == K_ILL);
  end

  // Unknown encodings keep the R-type operand shape with an add opcode so the ALU sees defined inputs
  always_comb begin
    dec_ctrl = 4'b0010;
    dec_in2  = rt_q;
    dec_kind = K_ILL;
    dec_dest = imm_q[15:11];
    dec_bne  = 1'b0;
    case (op_q)
      6'h00: begin
        dec_kind = K_WB;
        case (imm_q[5:0])
          6'h20, 6'h21: dec_ctrl = 4'b0010;
          6'h22, 6'h23: dec_ctrl = 4'b0110;
          6'h24:        dec_ctrl = 4'b0000;
          6'h25:        dec_ctrl = 4'b0001;
          6'h27:        dec_ctrl = 4'b1100;
          6'h2A:        dec_ctrl = 4'b0111;
          default:      dec_kind = K_ILL;
        endcase
      end
      6'h08, 6'h09: begin
        dec_kind = K_WB; dec_ctrl = 4'b0010; dec_in2 = imm_sx; dec_dest = rt_f_q;
      end
      6'h0A: begin
        dec_kind = K_WB; dec_ctrl = 4'b0111; dec_in2 = imm_sx; dec_dest = rt_f_q;
      end
      6'h0C: begin
        dec_kind = K_WB; dec_ctrl = 4'b0000; dec_in2 = imm_zx; dec_dest = rt_f_q;
      end
      6'h0D: begin
        dec_kind = K_WB; dec_ctrl = 4'b0001; dec_in2 = imm_zx; dec_dest = rt_f_q;
      end
      6'h04: begin
        dec_kind = K_BR; dec_ctrl = 4'b0110;
      end
      6'h05: begin
        dec_kind = K_BR; dec_ctrl = 4'b0110; dec_bne = 1'b1;
      end
      default: dec_kind = K_ILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      rt_f_q      <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      kind_q      <= K_WB;
      dest_q      <= '0;
      bne_q       <= 1'b0;
      ALU_in1     <= '0;
      ALU_in2     <= '0;
      ALU_control <= '0;
      br_target   <= '0;
      wb_reg      <= '0;
      wb_data     <= '0;
      br_taken    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= instr[31:26];
            rt_f_q <= instr[20:16];
            imm_q  <= instr[15:0];
            pc_q   <= pc_in;
            rs_q   <= rs_data;
            rt_q   <= rt_data;
          end
        end
        DECODE: begin
          ALU_control <= dec_ctrl;
          ALU_in1     <= rs_q;
          ALU_in2     <= dec_in2;
          br_target   <= pc_q + W'(4) + (imm_sx << 2);
          kind_q      <= dec_kind;
          dest_q      <= dec_dest;
          bne_q       <= dec_bne;
        end
        EXEC: begin
          if (kind_q == K_WB) begin
            wb_reg  <= dest_q;
            wb_data <= alu_result;
          end
          if (kind_q == K_BR) br_taken <= alu_zero ^ bne_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed cases plus randomized instructions against an instruction-level model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc_in = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] ALU_in1, ALU_in2;
  logic [3:0]  ALU_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        wb_valid, br_valid, br_taken, illegal_op;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data, br_target;

  int total = 0;
  int bad = 0;

  alu_issue_ctrl #(.W(32)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .pc_in(pc_in), .rs_data(rs_data), .rt_data(rt_data),
    .ALU_in1(ALU_in1), .ALU_in2(ALU_in2), .ALU_control(ALU_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Behavioural ALU on the DUT's registered operands
  always_comb begin
    case (ALU_control)
      4'b0010: alu_result = ALU_in1 + ALU_in2;
      4'b0110: alu_result = ALU_in1 - ALU_in2;
      4'b0000: alu_result = ALU_in1 & ALU_in2;
      4'b0001: alu_result = ALU_in1 | ALU_in2;
      4'b1100: alu_result = ~(ALU_in1 | ALU_in2);
      4'b0111: alu_result = ($signed(ALU_in1) < $signed(ALU_in2)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct packed {
    logic [1:0]  kind;   // 0 writeback, 1 branch, 2 illegal
    logic [3:0]  ctrl;
    logic [31:0] in2;
    logic [4:0]  dest;
    logic [31:0] res;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] sx;
    logic [31:0] zx;
    op = ins[31:26];
    fn = ins[5:0];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    e.kind = 2'd2; e.ctrl = 4'b0010; e.in2 = rt; e.dest = ins[15:11];
    e.res = rs + rt; e.taken = 1'b0; e.target = pc + 32'd4 + sx * 32'd4;
    if (op == 6'h00) begin
      e.kind = 2'd0;
      if (fn == 6'h20 || fn == 6'h21)      begin e.ctrl = 4'b0010; e.res = rs + rt; end
      else if (fn == 6'h22 || fn == 6'h23) begin e.ctrl = 4'b0110; e.res = rs - rt; end
      else if (fn == 6'h24)                begin e.ctrl = 4'b0000; e.res = rs & rt; end
      else if (fn == 6'h25)                begin e.ctrl = 4'b0001; e.res = rs | rt; end
      else if (fn == 6'h27)                begin e.ctrl = 4'b1100; e.res = ~(rs | rt); end
      else if (fn == 6'h2A) begin
        e.ctrl = 4'b0111; e.res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
      end else e.kind = 2'd2;
    end else if (op == 6'h08 || op == 6'h09) begin
      e.kind = 2'd0; e.ctrl = 4'b0010; e.in2 = sx; e.dest = ins[20:16]; e.res = rs + sx;
    end else if (op == 6'h0A) begin
      e.kind = 2'd0; e.ctrl = 4'b0111; e.in2 = sx; e.dest = ins[20:16];
      e.res = ($signed(rs) < $signed(sx)) ? 32'd1 : 32'd0;
    end else if (op == 6'h0C) begin
      e.kind = 2'd0; e.ctrl = 4'b0000; e.in2 = zx; e.dest = ins[20:16]; e.res = rs & zx;
    end else if (op == 6'h0D) begin
      e.kind = 2'd0; e.ctrl = 4'b0001; e.in2 = zx; e.dest = ins[20:16]; e.res = rs | zx;
    end else if (op == 6'h04 || op == 6'h05) begin
      e.kind = 2'd1; e.ctrl = 4'b0110;
      e.taken = (op == 6'h04) ? (rs == rt) : (rs != rt);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Follows one accepted instruction from just after its handshake edge to readiness again
  task automatic follow(input string tag, input exp_t e, input logic [31:0] rs);
    chk({tag, ".busy"}, instr_ready, 0);
    @(posedge clk); #1;
    chk({tag, ".ctrl"}, ALU_control, e.ctrl);
    chk({tag, ".in1"}, ALU_in1, rs);
    chk({tag, ".in2"}, ALU_in2, e.in2);
    @(posedge clk); #1;
    chk({tag, ".wb_valid"}, wb_valid, (e.kind == 2'd0 && e.dest != 5'd0));
    chk({tag, ".br_valid"}, br_valid, (e.kind == 2'd1));
    chk({tag, ".illegal"}, illegal_op, (e.kind == 2'd2));
    if (e.kind == 2'd0) begin
      chk({tag, ".wb_data"}, wb_data, e.res);
      if (e.dest != 5'd0) chk({tag, ".wb_reg"}, wb_reg, e.dest);
    end
    if (e.kind == 2'd1) begin
      chk({tag, ".br_taken"}, br_taken, e.taken);
      chk({tag, ".br_target"}, br_target, e.target);
    end
    @(posedge clk); #1;
    chk({tag, ".ready_back"}, instr_ready, 1);
    chk({tag, ".pulses_clear"}, {wb_valid, br_valid, illegal_op}, 0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".ready_wait"}, instr_ready, 1);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt);
    instr = ins; pc_in = pc; rs_data = rs; rt_data = rt;
    instr_valid = 1'b1;
  endtask

  task automatic run(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [31:0] rs, input logic [31:0] rt);
    wait_ready(tag);
    drive(ins, pc, rs, rt);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    follow(tag, model(ins, pc, rs, rt), rs);
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, rs[4:0], rt[4:0], imm};
  endfunction

  initial begin
    logic [5:0] fn_tbl [9];
    logic [5:0] op_tbl [10];
    exp_t e2;
    int gap;

    fn_tbl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};
    op_tbl = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h04, 6'h05, 6'h3F};

    #12;
    chk("reset.ready", instr_ready, 1);
    chk("reset.outs_a", {ALU_control, wb_valid, br_valid, br_taken, illegal_op, wb_reg}, 0);
    chk("reset.in1", ALU_in1, 0);
    chk("reset.in2", ALU_in2, 0);
    chk("reset.wb_data", wb_data, 0);
    chk("reset.br_target", br_target, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run("add", rtype(1, 2, 3, 6'h20), 32'h0, 32'd5, 32'd7);
    chk("add.wb12", wb_data, 32'd12);
    run("addi_m1", itype(6'h08, 1, 4, 16'hFFFF), 32'h0, 32'd0, 32'd0);
    chk("addi.all_ones", wb_data, 32'hFFFF_FFFF);
    run("ori_zx", itype(6'h0D, 1, 4, 16'h8000), 32'h0, 32'd1, 32'd0);
    chk("ori.result", wb_data, 32'h0000_8001);
    run("beq_taken", itype(6'h04, 1, 2, 16'h0003), 32'h100, 32'd9, 32'd9);
    chk("beq.target", br_target, 32'h110);
    run("bne_eq", itype(6'h05, 1, 2, 16'hFFFE), 32'h200, 32'd9, 32'd9);
    run("sub_r0", rtype(1, 2, 0, 6'h22), 32'h0, 32'd20, 32'd3);
    run("op3f", {6'h3F, 26'h123_4567}, 32'h40, 32'd1, 32'd2);
    run("slt_neg", rtype(1, 2, 9, 6'h2A), 32'h0, 32'hFFFF_FFF0, 32'd1);
    run("add_wrap", rtype(1, 2, 7, 6'h21), 32'h0, 32'hFFFF_FFFF, 32'd2);

    // Back-to-back: valid held high, second accept exactly 4 edges after the first
    wait_ready("b2b");
    drive(rtype(1, 2, 5, 6'h25), 32'h0, 32'h0F0F_0000, 32'h0000_00F0);
    @(posedge clk); #1;
    drive(rtype(3, 4, 6, 6'h27), 32'h0, 32'h1234_5678, 32'h0F0F_0F0F);
    e2 = model(instr, pc_in, rs_data, rt_data);
    gap = 1;
    while (!instr_ready && gap < 10) begin
      @(posedge clk); #1;
      gap++;
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("b2b.gap", gap, 4);
    follow("b2b.second", e2, 32'h1234_5678);

    // Reset asserted during EXEC drops the instruction
    wait_ready("rst_exec");
    drive(rtype(1, 2, 8, 6'h20), 32'h0, 32'd100, 32'd200);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_exec.ready", instr_ready, 1);
    chk("rst_exec.ctrl_pulses", {ALU_control, wb_valid, br_valid, illegal_op, br_taken, wb_reg}, 0);
    chk("rst_exec.in1", ALU_in1, 0);
    chk("rst_exec.in2", ALU_in2, 0);
    chk("rst_exec.wb_data", wb_data, 0);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_exec.no_wb", {wb_valid, br_valid, illegal_op}, 0);
    end
    run("after_rst", rtype(1, 2, 8, 6'h20), 32'h0, 32'd100, 32'd200);

    for (int k = 0; k < 40; k++) begin
      logic [5:0]  op;
      logic [31:0] ins;
      logic [31:0] rs;
      logic [31:0] rt;
      op = op_tbl[$urandom_range(0, 9)];
      rs = $urandom;
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      if (op == 6'h00)
        ins = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    fn_tbl[$urandom_range(0, 8)]);
      else
        ins = itype(op, $urandom_range(0, 31), $urandom_range(0, 31), 16'($urandom));
      run("rand", ins, $urandom & 32'hFFFF_FFFC, rs, rt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
